// File: rtl/tof_readout_scheduler_pkg.sv
// Shared widths, command codes and types for the ToF readout scheduler.
package tof_readout_scheduler_pkg;

  localparam int unsigned NB_OF_SENSORS = 8;
  localparam int unsigned TOF_IDX_W     = 3;
  localparam int unsigned TOF_DATA_W    = 22;
  localparam int unsigned TOF_RES_W     = TOF_IDX_W + TOF_DATA_W;
  localparam int unsigned TOF_CMD_W     = 4;
  localparam int unsigned TOF_CMD_BUS_W = TOF_CMD_W * NB_OF_SENSORS;

  // Command nibbles understood by the comm block; 0 is reserved as NOP.
  localparam logic [TOF_CMD_W-1:0] TOF_CMD_NOP   = 4'h0;
  localparam logic [TOF_CMD_W-1:0] TOF_CMD_START = 4'h1;
  localparam logic [TOF_CMD_W-1:0] TOF_CMD_STOP  = 4'h2;
  localparam logic [TOF_CMD_W-1:0] TOF_CMD_RESET = 4'h3;
  localparam logic [TOF_CMD_W-1:0] TOF_CMD_CALIB = 4'h4;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StCapture
  } sched_state_e;

  typedef struct packed {
    logic [TOF_IDX_W-1:0]  sensor_id;
    logic [TOF_DATA_W-1:0] data;
  } tof_result_t;

  // Place one command nibble at its sensor slot, all other slots NOP.
  function automatic logic [TOF_CMD_BUS_W-1:0] cmd_place(input logic [TOF_IDX_W-1:0] sensor,
                                                          input logic [TOF_CMD_W-1:0] code);
    logic [TOF_CMD_BUS_W-1:0] bus;
    bus = '0;
    bus[sensor*TOF_CMD_W +: TOF_CMD_W] = code;
    return bus;
  endfunction

endpackage

// File: rtl/tof_sync_fifo.sv
// Synchronous show-ahead FIFO; writes when full and reads when empty are ignored.
module tof_sync_fifo #(
  parameter int unsigned Width = 25,
  parameter int unsigned Depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop_data = mem[rd_ptr_q[AddrW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AddrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tof_readout_scheduler.sv
// Sequencer between the 8-channel ToF comm block and the host: latches ready flags,
// round-robin selects a sensor, captures its result into a FIFO, and drives host commands.
module tof_readout_scheduler
  import tof_readout_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CMD_HOLD      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NB_OF_SENSORS-1:0] ready_in,
  input  logic [TOF_DATA_W-1:0]    data_in,
  output logic [TOF_IDX_W-1:0]     tof_index,
  output logic [TOF_CMD_BUS_W-1:0] tof_cmd,
  input  logic [NB_OF_SENSORS-1:0] enable_mask,
  input  logic                     cmd_valid,
  input  logic [TOF_IDX_W-1:0]     cmd_sensor,
  input  logic [TOF_CMD_W-1:0]     cmd_code,
  output logic                     cmd_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [TOF_RES_W-1:0]     res_data,
  output logic [NB_OF_SENSORS-1:0] overrun,
  input  logic                     overrun_clr,
  output logic                     frame_done
);

  localparam int unsigned HoldW = (CMD_HOLD > 1) ? $clog2(CMD_HOLD) : 1;

  // First requesting sensor at or after ptr, wrapping 7 -> 0.
  function automatic logic [TOF_IDX_W-1:0] rr_pick(input logic [NB_OF_SENSORS-1:0] req,
                                                    input logic [TOF_IDX_W-1:0] ptr);
    logic [TOF_IDX_W-1:0] idx;
    logic [TOF_IDX_W-1:0] pick;
    logic                 found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NB_OF_SENSORS; k++) begin
      idx = ptr + TOF_IDX_W'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  sched_state_e state_q, state_d;

  logic [TOF_IDX_W-1:0]     grant_q, grant_d;
  logic [TOF_IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [2:0]               settle_cnt_q, settle_cnt_d;
  logic [NB_OF_SENSORS-1:0] pending_q, pending_d;
  logic [NB_OF_SENSORS-1:0] overrun_q, overrun_d;
  logic [NB_OF_SENSORS-1:0] seen_q, seen_d;
  logic [NB_OF_SENSORS-1:0] capture_mask;

  logic cmd_busy_q, cmd_busy_d;
  logic [HoldW-1:0]     cmd_cnt_q, cmd_cnt_d;
  logic [TOF_IDX_W-1:0] cmd_sensor_q, cmd_sensor_d;
  logic [TOF_CMD_W-1:0] cmd_code_q, cmd_code_d;

  logic        fifo_full, fifo_empty, fifo_pop;
  tof_result_t push_res;
  logic        can_grant, settle_done, frame_hit;
  logic        load_grant, capture;

  assign can_grant   = (pending_q != '0) && !fifo_full;
  assign settle_done = (settle_cnt_q == 3'(SETTLE_CYCLES - 1));
  assign frame_hit   = (enable_mask != '0) && ((seen_q & enable_mask) == enable_mask);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (can_grant) state_d = StSelect;
      StSelect:  if (settle_done) state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs: grant load in IDLE, result push in CAPTURE.
  always_comb begin
    load_grant = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle:    load_grant = can_grant;
      StSelect:  ;
      StCapture: capture = 1'b1;
      default:   ;
    endcase
  end

  // Sensor bookkeeping next-state: a same-cycle ready always beats the capture clear.
  always_comb begin
    capture_mask = capture ? (NB_OF_SENSORS'(1) << grant_q) : '0;
    grant_d      = load_grant ? rr_pick(pending_q, rr_ptr_q) : grant_q;
    rr_ptr_d     = capture ? grant_q + TOF_IDX_W'(1) : rr_ptr_q;
    settle_cnt_d = (state_q == StSelect && !settle_done) ? settle_cnt_q + 3'd1 : 3'd0;
    pending_d    = (pending_q & ~capture_mask) | ready_in;
    overrun_d    = (overrun_clr ? '0 : overrun_q) | (ready_in & pending_q & ~capture_mask);
    seen_d       = (frame_hit ? '0 : seen_q) | capture_mask;
  end

  // Scheduler datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      settle_cnt_q <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      seen_q       <= '0;
    end else begin
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      settle_cnt_q <= settle_cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      seen_q       <= seen_d;
    end
  end

  // Command hold next-state: accept only while idle, then count down the hold.
  always_comb begin
    cmd_busy_d   = cmd_busy_q;
    cmd_cnt_d    = cmd_cnt_q;
    cmd_sensor_d = cmd_sensor_q;
    cmd_code_d   = cmd_code_q;
    if (!cmd_busy_q) begin
      if (cmd_valid) begin
        cmd_busy_d   = 1'b1;
        cmd_cnt_d    = HoldW'(CMD_HOLD - 1);
        cmd_sensor_d = cmd_sensor;
        cmd_code_d   = cmd_code;
      end
    end else if (cmd_cnt_q == '0) begin
      cmd_busy_d = 1'b0;
      cmd_code_d = TOF_CMD_NOP;
    end else begin
      cmd_cnt_d = cmd_cnt_q - HoldW'(1);
    end
  end

  // Command path registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_busy_q   <= 1'b0;
      cmd_cnt_q    <= '0;
      cmd_sensor_q <= '0;
      cmd_code_q   <= TOF_CMD_NOP;
    end else begin
      cmd_busy_q   <= cmd_busy_d;
      cmd_cnt_q    <= cmd_cnt_d;
      cmd_sensor_q <= cmd_sensor_d;
      cmd_code_q   <= cmd_code_d;
    end
  end

  assign push_res = '{sensor_id: grant_q, data: data_in};
  assign fifo_pop = res_valid && res_ready;

  tof_sync_fifo #(
    .Width (TOF_RES_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (push_res),
    .pop       (fifo_pop),
    .pop_data  (res_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign res_valid  = !fifo_empty;
  assign tof_index  = grant_q;
  assign overrun    = overrun_q;
  assign frame_done = frame_hit;
  assign cmd_ready  = !cmd_busy_q;
  assign tof_cmd    = cmd_busy_q ? cmd_place(cmd_sensor_q, cmd_code_q) : '0;

endmodule
